// File: rtl/aluctrl_pipe.sv
// Registered ALU-control decoder with valid/ready handshake and RV32M busy sequencing.
// Optional feature macro: ALUCTRL_MEXT_EN (M-extension decode, MDBUSY state, busy counter).
module aluctrl_pipe #(
    parameter int OPW        = 5,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           valid_i,
    output logic           ready_o,
    input  logic [6:0]     aluinst_i,
    input  logic [2:0]     f3_i,
    input  logic [6:0]     f7_i,
    output logic           valid_o,
    input  logic           ready_i,
    output logic [OPW-1:0] aluope_o,
    output logic           illegal_o,
    output logic           mdbusy_o,
    output logic           mddone_o
);

    if (OPW < 5 || MUL_CYCLES < 1 || DIV_CYCLES < 1) begin : g_bad_params
        $error("aluctrl_pipe: OPW must be >= 5 and cycle counts >= 1");
    end

`ifdef ALUCTRL_MEXT_EN
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {EMPTY, FULL, MDBUSY} state_t;

    logic [CW-1:0] cnt_q;
    logic          mext_q;
    logic          div_q;
`else
    typedef enum logic [1:0] {EMPTY, FULL} state_t;
`endif

    state_t         state_q, state_d;
    logic [4:0]     dec_code;
    logic           dec_ill;
    logic [OPW-1:0] ope_d;
    logic           accept;

    always_comb begin
        dec_code = 5'b00000;
        dec_ill  = 1'b0;
        case (aluinst_i)
            7'b0110011: begin
                if (f7_i == 7'b0000000)
                    dec_code = {2'b00, f3_i};
                else if (f7_i == 7'b0100000 && (f3_i == 3'b000 || f3_i == 3'b101))
                    dec_code = {2'b01, f3_i};
`ifdef ALUCTRL_MEXT_EN
                else if (f7_i == 7'b0000001)
                    dec_code = {2'b10, f3_i};
`endif
                else
                    dec_ill = 1'b1;
            end
            7'b0010011: begin
                if (f3_i == 3'b001) begin
                    if (f7_i == 7'b0000000) dec_code = 5'b00001;
                    else                    dec_ill  = 1'b1;
                end else if (f3_i == 3'b101) begin
                    if (f7_i == 7'b0000000)      dec_code = 5'b00101;
                    else if (f7_i == 7'b0100000) dec_code = 5'b01101;
                    else                         dec_ill  = 1'b1;
                end else begin
                    dec_code = {2'b00, f3_i};
                end
            end
            7'b0000011, 7'b0100011, 7'b1101111,
            7'b1100111, 7'b0110111, 7'b0010111: dec_code = 5'b00000;
            7'b1100011: begin
                case (f3_i[2:1])
                    2'b00:   dec_code = 5'b00100;
                    2'b10:   dec_code = 5'b00010;
                    2'b11:   dec_code = 5'b00011;
                    default: dec_ill  = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

    always_comb begin
        ope_d      = '0;
        ope_d[4:0] = dec_code;
        if (dec_ill) ope_d = '1;
    end

    assign accept = valid_i && ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (valid_i) state_d = FULL;
            FULL: begin
                if (ready_i && !valid_i) state_d = EMPTY;
`ifdef ALUCTRL_MEXT_EN
                if (ready_i && mext_q) state_d = MDBUSY;
`endif
            end
`ifdef ALUCTRL_MEXT_EN
            MDBUSY: if (cnt_q == '0) state_d = EMPTY;
`endif
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        ready_o = 1'b0;
        valid_o = 1'b0;
`ifdef ALUCTRL_MEXT_EN
        mdbusy_o = 1'b0;
        mddone_o = 1'b0;
`endif
        case (state_q)
            EMPTY: ready_o = 1'b1;
            FULL: begin
                valid_o = 1'b1;
`ifdef ALUCTRL_MEXT_EN
                ready_o = ready_i && !mext_q;
`else
                ready_o = ready_i;
`endif
            end
`ifdef ALUCTRL_MEXT_EN
            MDBUSY: begin
                mdbusy_o = 1'b1;
                mddone_o = (cnt_q == '0);
            end
`endif
            default: ready_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aluope_o  <= '0;
            illegal_o <= 1'b0;
        end else if (accept) begin
            aluope_o  <= ope_d;
            illegal_o <= dec_ill;
        end
    end

`ifdef ALUCTRL_MEXT_EN
    // The div/mul choice is captured at accept so the handoff load needs no live inputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mext_q <= 1'b0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (accept) begin
                mext_q <= dec_code[4] && !dec_ill;
                div_q  <= f3_i[2];
            end
            if (state_q == FULL && ready_i && mext_q)
                cnt_q <= div_q ? DIV_LOAD : MUL_LOAD;
            else if (state_q == MDBUSY && cnt_q != '0)
                cnt_q <= cnt_q - 1'b1;
        end
    end
`else
    assign mdbusy_o = 1'b0;
    assign mddone_o = 1'b0;
`endif

endmodule

// File: tb/tb_aluctrl_pipe.sv
// Self-checking bench for aluctrl_pipe: directed vector table, handshake corner cases, random vs. model.
module tb_aluctrl_pipe;
    localparam int OPW = 5;
    localparam int MULC = 4;
    localparam int DIVC = 32;
    localparam int NV = 28;

    logic clk = 1'b0;
    logic rst_i, valid_i, ready_i;
    logic [6:0] aluinst_i, f7_i;
    logic [2:0] f3_i;
    logic ready_o, valid_o, illegal_o, mdbusy_o, mddone_o;
    logic [OPW-1:0] aluope_o;

    int n_chk = 0;
    int n_fail = 0;

    aluctrl_pipe #(.OPW(OPW), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .aluinst_i(aluinst_i), .f3_i(f3_i), .f7_i(f7_i), .valid_o(valid_o),
        .ready_i(ready_i), .aluope_o(aluope_o), .illegal_o(illegal_o),
        .mdbusy_o(mdbusy_o), .mddone_o(mddone_o)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] code;
        logic       ill;
    } vec_t;

    vec_t vt [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        valid_i = v; aluinst_i = op; f3_i = f3; f7_i = f7;
    endtask

    // Reference decode straight from the instruction-set rules; returns {illegal, code}.
    function automatic logic [5:0] ref_dec(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        int c;
        c = -1;
        if (op inside {7'h03, 7'h23, 7'h6F, 7'h67, 7'h37, 7'h17}) c = 0;
        else if (op == 7'h63) begin
            if (f3 < 2) c = 4;
            else if (f3 == 4 || f3 == 5) c = 2;
            else if (f3 >= 6) c = 3;
        end else if (op == 7'h13) begin
            if (f3 == 1) c = (f7 == 0) ? 1 : -1;
            else if (f3 == 5) c = (f7 == 0) ? 5 : (f7 == 7'h20) ? 13 : -1;
            else c = int'(f3);
        end else if (op == 7'h33) begin
            if (f7 == 0) c = int'(f3);
            else if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) c = 8 + int'(f3);
`ifdef ALUCTRL_MEXT_EN
            else if (f7 == 7'h01) c = 16 + int'(f3);
`endif
        end
        if (c < 0) return 6'b111111;
        return {1'b0, 5'(c)};
    endfunction

    task automatic do_reset();
        rst_i = 1'b1;
        drive(1'b0, 7'h0, 3'h0, 7'h0);
        ready_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
    endtask

`ifdef ALUCTRL_MEXT_EN
    // Issue one M op with a follow-up add waiting; measure busy/done/ready-low cycles.
    task automatic run_md(input logic [2:0] f3, input int lat, input string tag);
        int busy, done_at, ndone, low;
        drive(1'b1, 7'h33, f3, 7'h01);
        ready_i = 1'b1;
        @(negedge clk);
        chk({tag, "_code"}, aluope_o, {2'b10, f3});
        chk({tag, "_vld"}, valid_o, 1);
        drive(1'b1, 7'h33, 3'd0, 7'h00);
        #1;
        chk({tag, "_handoff_rdy"}, ready_o, 0);
        busy = 0; done_at = 0; ndone = 0; low = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!mdbusy_o) break;
            busy++;
            if (mddone_o) begin done_at = busy; ndone++; end
            if (!ready_o) low++;
            if (valid_o) chk({tag, "_vld_in_busy"}, valid_o, 0);
        end
        chk({tag, "_busy_cycles"}, busy, lat);
        chk({tag, "_done_pos"}, done_at, lat);
        chk({tag, "_done_count"}, ndone, 1);
        chk({tag, "_rdy_low"}, low, lat + 1);
        chk({tag, "_rdy_after"}, ready_o, 1);
        @(negedge clk);
        chk({tag, "_next_vld"}, valid_o, 1);
        chk({tag, "_next_code"}, aluope_o, 0);
        drive(1'b0, 7'h0, 3'h0, 7'h0);
        @(negedge clk);
    endtask
`endif

    initial begin
        logic [5:0] d;
        logic m_hold, m_ill, m_mext, m_div, exp_rdy;
        logic [4:0] m_code;
        int m_busy;
        logic [6:0] ops [10];
        logic [6:0] f7s [3];
        logic seen;

        vt[0]  = '{7'h33, 3'd0, 7'h00, 5'h00, 1'b0};
        vt[1]  = '{7'h33, 3'd0, 7'h20, 5'h08, 1'b0};
        vt[2]  = '{7'h33, 3'd5, 7'h20, 5'h0D, 1'b0};
        vt[3]  = '{7'h63, 3'd6, 7'h00, 5'h03, 1'b0};
        vt[4]  = '{7'h63, 3'd2, 7'h00, 5'h1F, 1'b1};
        vt[5]  = '{7'h33, 3'd1, 7'h20, 5'h1F, 1'b1};
        vt[6]  = '{7'h33, 3'd1, 7'h00, 5'h01, 1'b0};
        vt[7]  = '{7'h33, 3'd7, 7'h00, 5'h07, 1'b0};
        vt[8]  = '{7'h33, 3'd3, 7'h7F, 5'h1F, 1'b1};
        vt[9]  = '{7'h13, 3'd1, 7'h00, 5'h01, 1'b0};
        vt[10] = '{7'h13, 3'd1, 7'h20, 5'h1F, 1'b1};
        vt[11] = '{7'h13, 3'd5, 7'h20, 5'h0D, 1'b0};
        vt[12] = '{7'h13, 3'd5, 7'h00, 5'h05, 1'b0};
        vt[13] = '{7'h13, 3'd5, 7'h7F, 5'h1F, 1'b1};
        vt[14] = '{7'h13, 3'd0, 7'h7F, 5'h00, 1'b0};
        vt[15] = '{7'h13, 3'd7, 7'h55, 5'h07, 1'b0};
        vt[16] = '{7'h03, 3'd2, 7'h7F, 5'h00, 1'b0};
        vt[17] = '{7'h6F, 3'd3, 7'h11, 5'h00, 1'b0};
        vt[18] = '{7'h37, 3'd6, 7'h00, 5'h00, 1'b0};
        vt[19] = '{7'h63, 3'd7, 7'h00, 5'h03, 1'b0};
        vt[20] = '{7'h63, 3'd0, 7'h00, 5'h04, 1'b0};
        vt[21] = '{7'h63, 3'd1, 7'h00, 5'h04, 1'b0};
        vt[22] = '{7'h63, 3'd4, 7'h00, 5'h02, 1'b0};
        vt[23] = '{7'h63, 3'd5, 7'h00, 5'h02, 1'b0};
        vt[24] = '{7'h63, 3'd3, 7'h00, 5'h1F, 1'b1};
        vt[25] = '{7'h7F, 3'd0, 7'h00, 5'h1F, 1'b1};
        vt[26] = '{7'h00, 3'd0, 7'h00, 5'h1F, 1'b1};
        vt[27] = '{7'h67, 3'd0, 7'h00, 5'h00, 1'b0};

        // Reset values
        rst_i = 1'b1; ready_i = 1'b0;
        drive(1'b0, 7'h0, 3'h0, 7'h0);
        #1;
        chk("rst_rdy", ready_o, 1);
        chk("rst_vld", valid_o, 0);
        chk("rst_ope", aluope_o, 0);
        chk("rst_ill", illegal_o, 0);
        chk("rst_busy", mdbusy_o, 0);
        chk("rst_done", mddone_o, 0);
        @(negedge clk); @(negedge clk);
        rst_i = 1'b0;
        chk("post_rst_rdy", ready_o, 1);

        // Back-to-back vectors with ready_i high
        ready_i = 1'b1;
        drive(1'b1, vt[0].op, vt[0].f3, vt[0].f7);
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d_vld", i), valid_o, 1);
            chk($sformatf("vec%0d_code", i), aluope_o, vt[i].code);
            chk($sformatf("vec%0d_ill", i), illegal_o, vt[i].ill);
            if (i + 1 < NV) drive(1'b1, vt[i+1].op, vt[i+1].f3, vt[i+1].f7);
            else            drive(1'b0, 7'h0, 3'h0, 7'h0);
        end
        @(negedge clk);
        chk("drain_vld", valid_o, 0);

        // Output stall: ready_i low for 3 cycles with a new op waiting
        drive(1'b1, 7'h33, 3'd0, 7'h20);
        @(negedge clk);
        chk("hold_a_code", aluope_o, 5'h08);
        drive(1'b1, 7'h33, 3'd5, 7'h20);
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("hold%0d_rdy", i), ready_o, 0);
            @(negedge clk);
            chk($sformatf("hold%0d_code", i), aluope_o, 5'h08);
            chk($sformatf("hold%0d_vld", i), valid_o, 1);
        end
        ready_i = 1'b1;
        #1;
        chk("release_rdy", ready_o, 1);
        @(negedge clk);
        chk("release_code", aluope_o, 5'h0D);
        drive(1'b0, 7'h0, 3'h0, 7'h0);
        @(negedge clk);

        // Reset while FULL and stalled discards the op
        drive(1'b1, 7'h63, 3'd6, 7'h00);
        ready_i = 1'b0;
        @(negedge clk);
        chk("full_vld", valid_o, 1);
        rst_i = 1'b1;
        #1;
        chk("rst_full_vld", valid_o, 0);
        chk("rst_full_rdy", ready_o, 1);
        do_reset();

`ifdef ALUCTRL_MEXT_EN
        run_md(3'd0, MULC, "mul");
        run_md(3'd4, DIVC, "div");

        // Reset on the 10th busy cycle of a divide
        drive(1'b1, 7'h33, 3'd5, 7'h01);
        ready_i = 1'b1;
        @(negedge clk);
        drive(1'b0, 7'h0, 3'h0, 7'h0);
        begin
            int busy;
            busy = 0;
            for (int i = 0; i < 50 && busy < 10; i++) begin
                @(negedge clk);
                if (mdbusy_o) busy++;
            end
            chk("mdrst_reached10", busy, 10);
        end
        rst_i = 1'b1;
        #1;
        chk("mdrst_busy", mdbusy_o, 0);
        chk("mdrst_rdy", ready_o, 1);
        chk("mdrst_vld", valid_o, 0);
        @(negedge clk);
        rst_i = 1'b0;
        drive(1'b1, 7'h33, 3'd0, 7'h00);
        @(negedge clk);
        chk("mdrst_add_vld", valid_o, 1);
        chk("mdrst_add_code", aluope_o, 0);
        drive(1'b0, 7'h0, 3'h0, 7'h0);
        @(negedge clk);
`else
        // Without the M extension a mul is just an illegal op
        drive(1'b1, 7'h33, 3'd0, 7'h01);
        ready_i = 1'b1;
        @(negedge clk);
        drive(1'b0, 7'h0, 3'h0, 7'h0);
        chk("mul_noext_code", aluope_o, 5'h1F);
        chk("mul_noext_ill", illegal_o, 1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (mdbusy_o || mddone_o) seen = 1'b1;
            @(negedge clk);
        end
        chk("mul_noext_nobusy", seen, 0);
        chk("mul_noext_rdy", ready_o, 1);
`endif

        // Random traffic against a transaction-level model
        do_reset();
        ops = '{7'h33, 7'h33, 7'h33, 7'h13, 7'h13, 7'h63, 7'h03, 7'h23, 7'h6F, 7'h37};
        f7s = '{7'h00, 7'h20, 7'h01};
        m_hold = 1'b0; m_busy = 0; m_code = '0; m_ill = 1'b0; m_mext = 1'b0; m_div = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            chk("rnd_vld", valid_o, m_hold);
            if (m_hold) begin
                chk("rnd_code", aluope_o, m_code);
                chk("rnd_ill", illegal_o, m_ill);
            end
            chk("rnd_busy", mdbusy_o, m_busy > 0);
            chk("rnd_done", mddone_o, m_busy == 1);
            begin
                int oi, fi;
                oi = $urandom_range(0, 10);
                fi = $urandom_range(0, 3);
                drive($urandom_range(0, 3) != 0,
                      (oi == 10) ? 7'($urandom) : ops[oi],
                      3'($urandom),
                      (fi == 3) ? 7'($urandom) : f7s[fi]);
                ready_i = ($urandom_range(0, 3) != 0);
            end
            #1;
            exp_rdy = (m_busy == 0) && (!m_hold || (ready_i && !m_mext));
            chk("rnd_rdy", ready_o, exp_rdy);
            d = ref_dec(aluinst_i, f3_i, f7_i);
            if (m_busy > 0) m_busy--;
            else if (m_hold && ready_i && m_mext) begin
                m_busy = m_div ? DIVC : MULC;
                m_hold = 1'b0;
            end else if (m_hold && ready_i && !valid_i) m_hold = 1'b0;
            else if (valid_i && exp_rdy) begin
                m_hold = 1'b1;
                m_ill  = d[5];
                m_code = d[4:0];
                m_mext = !d[5] && d[4];
                m_div  = f3_i[2];
            end
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/aluctrl_pipe.md
# aluctrl_pipe

Registered, handshaked successor to the combinational ALU-control decoder: accepts one instruction's opcode/funct3/funct7 per cycle and emits a parametrised-width ALU operation code plus an illegal-instruction flag. It sits between decode and execute. It adds full funct7 checking, unsigned branch compares, and RV32M sequencing, which stalls the input while the multi-cycle multiply/divide unit runs.

## Interface
Parameters:
- OPW, 5, width of aluope_o; must be >= 5; codes are zero-extended.
- MUL_CYCLES, 4, execute cycles of a MUL* op; must be >= 1.
- DIV_CYCLES, 32, execute cycles of a DIV*/REM* op; must be >= 1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- valid_i  in  1  input instruction fields valid.
- ready_o  out  1  block accepts input this cycle.
- aluinst_i  in  7  instruction opcode [6:0].
- f3_i  in  3  funct3.
- f7_i  in  7  full funct7.
- valid_o  out  1  aluope_o/illegal_o valid.
- ready_i  in  1  execute stage consumes output.
- aluope_o  out  OPW  ALU operation code.
- illegal_o  out  1  decoded instruction is illegal.
- mdbusy_o  out  1  multiply/divide in progress.
- mddone_o  out  1  one-cycle pulse at the end of the multiply/divide.

## Operation
Decode rules, with the result registered on accept. Code bit 4 = M-extension, and bits [3:0] are as listed.
- Opcode 0110011 (R-type), f7=0000000: code {0,f3}. f7=0100000 is legal only for f3=000 and f3=101, with code {1,f3}. f7=0000001: code 1_0,f3 (M-extension).
- Opcode 0010011 (OP-IMM), f3=001: f7 must be 0000000, code 0001. f3=101: f7=0000000 gives code 0101, f7=0100000 gives code 1101. Any other f3: code {0,f3}, f7 ignored.
- Opcodes 0000011, 0100011, 1101111, 1100111, 0110111 and 0010111 (load, store, JAL, JALR, LUI, AUIPC): code 0000 (add).
- Opcode 1100011 (branch):
  - f3=000 or 001: code 0100 (xor).
  - f3=100 or 101: code 0010 (slt).
  - f3=110 or 111: code 0011 (sltu).
  - f3=010 or 011: illegal.
- Anything else, and every illegal case above, gives aluope_o all ones and illegal_o=1.

State machine, with state reg in {EMPTY, FULL, MDBUSY}:
- EMPTY: ready_o=1, valid_o=0. valid_i latches the decode and moves to FULL.
- FULL: valid_o=1.
  - ready_o = ready_i AND the latched op is not M-extension.
  - On ready_i with a latched M-extension op, load the counter with (f3[2] ? DIV_CYCLES : MUL_CYCLES) - 1 and move to MDBUSY.
  - Otherwise, on ready_i: with valid_i, latch the new op and stay in FULL; without valid_i, move to EMPTY.
  - Without ready_i, hold all outputs stable.
- MDBUSY: ready_o=0, valid_o=0, mdbusy_o=1, and the counter decrements each cycle. With the counter at 0, mddone_o=1 for that cycle, and the next state is EMPTY.
- Counter width is $clog2(max(MUL_CYCLES,DIV_CYCLES)).
- Illegal ops pass through FULL like normal ops and never enter MDBUSY.

## Timing
- Reset values: state EMPTY, aluope_o=0, illegal_o=0, valid_o=0, mdbusy_o=0, mddone_o=0, counter 0. ready_o=1 during and after reset.
- Latency is 1 cycle from accept (valid_i&&ready_o at edge N) to valid_o at N+1. Non-M throughput is 1 op/cycle with ready_i held high.
- ready_o depends combinationally on ready_i in FULL. There is no combinational path from valid_i to any output.
- For an M-extension op, ready_o stays 0 for the handoff cycle plus the LAT MDBUSY cycles. The earliest next accept is in the cycle after mddone_o.
- Reset asserted mid-MDBUSY or mid-FULL returns to reset values immediately, and the pending op is discarded.

## Configuration
- ALUCTRL_MEXT_EN defined: M-extension decode, the MDBUSY state, the counter and mddone_o/mdbusy_o behaviour are as above.
- ALUCTRL_MEXT_EN undefined: R-type f7=0000001 decodes as illegal. The MDBUSY state and counter are absent, and mdbusy_o and mddone_o are tied to 0.

## Test plan
- Reset, then back-to-back add, sub (0110011, f3=000, f7=0100000) and sra, with ready_i=1 → valid_o from the cycle after the first accept. Codes are 00000, 01000 and 01101 on consecutive cycles, with illegal_o=0.
- Branch f3=110 → 00011. Branch f3=010 → aluope_o=11111 and illegal_o=1. R-type f7=0100000 with f3=001 → illegal_o=1.
- Hold ready_i=0 for 3 cycles with valid_i=1 → aluope_o stable, ready_o=0, no new op latched. Release → the next op appears on the following cycle.
- MEXT_EN with MUL_CYCLES=4: mul (f7=0000001, f3=000) → code 10000, then mdbusy_o high for 4 cycles, mddone_o on the 4th, and ready_o low for 5 cycles in total. div (f3=100) with DIV_CYCLES=32 → 32 busy cycles.
- Assert rst_i on the 10th MDBUSY cycle → mdbusy_o=0, ready_o=1 and valid_o=0 immediately, and a new add is accepted the first edge after release.
- MEXT_EN undefined: mul encoding → aluope_o=11111, illegal_o=1, and mdbusy_o never asserts.
